// File: rtl/alu_sel_defs.sv
// rtl/alu_sel_defs.sv - shared ALU result select codes and default legality mask
//
// Purpose : select-code names for the ALU result mux and the mask of codes
//           that map to a real functional unit.
// Ports   : none (package).

package alu_sel_defs;

   typedef enum logic [2:0] {
      SEL_AND = 3'd0,
      SEL_OR  = 3'd1,
      SEL_ADD = 3'd2,
      SEL_SLT = 3'd3,
      SEL_XOR = 3'd5
   } alu_sel_e;

   localparam int DEFAULT_WIDTH  = 24;
   localparam int DEFAULT_NUM_IN = 8;

   // Built from the code names so the mask can never drift from the enum.
   localparam logic [DEFAULT_NUM_IN-1:0] LEGAL_MASK_DEFAULT =
      (8'd1 << SEL_AND) | (8'd1 << SEL_OR) | (8'd1 << SEL_ADD) |
      (8'd1 << SEL_SLT) | (8'd1 << SEL_XOR);   // 8'b0010_1111

endpackage

// File: rtl/result_skid_buf.sv
// rtl/result_skid_buf.sv - one output register plus one skid register, valid/ready
//
// Purpose : registered valid/ready stage holding up to two beats (output reg
//           and skid reg S). in_ready is a pure register output (!S_full), so
//           there is no combinational path from out_ready to in_ready.
// Ports   :
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_data/in_valid     upstream beat
//   in_ready             block can accept this cycle
//   out_data/out_valid   registered beat presented downstream
//   out_ready            downstream accepts this cycle

module result_skid_buf #(
   parameter int PW = 26
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [PW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [PW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   logic [PW-1:0] out_q;
   logic          out_vld_q;
   logic [PW-1:0] skid_q;
   logic          skid_full_q;

   logic accept;
   logic out_load;

   assign in_ready  = !skid_full_q;
   assign accept    = in_valid && !skid_full_q;
   // Output reg may take a new beat when empty or when its beat leaves now.
   assign out_load  = !out_vld_q || out_ready;

   assign out_data  = out_q;
   assign out_valid = out_vld_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= '0;
         out_vld_q   <= 1'b0;
         skid_q      <= '0;
         skid_full_q <= 1'b0;
      end else if (out_load) begin
         if (skid_full_q) begin
            // S is older than anything upstream; in_ready was 0, so no
            // beat is accepted this cycle.
            out_q       <= skid_q;
            out_vld_q   <= 1'b1;
            skid_full_q <= 1'b0;
         end else if (accept) begin
            out_q     <= in_data;
            out_vld_q <= 1'b1;
         end else begin
            // Data is left as-is; only the valid flag drops.
            out_vld_q <= 1'b0;
         end
      end else if (accept) begin
         // Output is stalled: park the accepted beat in S.
         skid_q      <= in_data;
         skid_full_q <= 1'b1;
      end
   end

endmodule

// File: rtl/alu_result_select_pipe.sv
// rtl/alu_result_select_pipe.sv - registered ALU result selector with skid buffer
//
// Purpose : picks one of NUM_IN functional-unit results by sel, flags unmapped
//           codes (data forced to 0), computes a zero flag, and registers the
//           beat behind a 2-entry valid/ready skid buffer.
// Ports   :
//   clk, reset     rising-edge clock, synchronous active-high reset
//   in_data        packed results, input i at [i*WIDTH +: WIDTH]
//   sel            result select code
//   in_valid       upstream has a result/sel pair
//   in_ready       block can accept this cycle
//   out_data       selected result
//   out_zero       out_data == 0, travels with the beat
//   out_illegal    beat came from an illegal sel
//   out_valid      out_* valid
//   out_ready      downstream accepts this cycle
//   err_sticky     an illegal sel was accepted since the last clear
//   err_clear      clears err_sticky (an illegal accept in the same cycle wins)

module alu_result_select_pipe
   import alu_sel_defs::*;
#(
   parameter int                WIDTH      = DEFAULT_WIDTH,
   parameter int                NUM_IN     = DEFAULT_NUM_IN,
   parameter int                SEL_W      = $clog2(NUM_IN),
   parameter logic [NUM_IN-1:0] LEGAL_MASK = NUM_IN'(LEGAL_MASK_DEFAULT)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_zero,
   output logic                    out_illegal,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err_sticky,
   input  logic                    err_clear
);

   localparam int PW = WIDTH + 2;

   logic [WIDTH-1:0] mux_data;
   logic             sel_legal;
   logic [WIDTH-1:0] res_data;
   logic             res_zero;
   logic [PW-1:0]    res_payload;
   logic [PW-1:0]    out_payload;
   logic             accept;

   // A code that matches no input (sel >= NUM_IN) leaves sel_legal at 0,
   // which covers the range check without a separate compare.
   always_comb begin
      mux_data  = '0;
      sel_legal = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (sel == SEL_W'(i)) begin
            mux_data  = in_data[i*WIDTH +: WIDTH];
            sel_legal = LEGAL_MASK[i];
         end
      end
   end

   // Illegal codes never forward whatever happens to sit on an unused lane.
   assign res_data    = sel_legal ? mux_data : '0;
   assign res_zero    = (res_data == '0);
   assign res_payload = {!sel_legal, res_zero, res_data};

   result_skid_buf #(
      .PW (PW)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_data   (res_payload),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_payload),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign out_illegal = out_payload[PW-1];
   assign out_zero    = out_payload[PW-2];
   assign out_data    = out_payload[WIDTH-1:0];

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_sticky <= 1'b0;
      end else if (accept && !sel_legal) begin
         err_sticky <= 1'b1;
      end else if (err_clear) begin
         err_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_result_select_pipe.sv
// tb/tb_alu_result_select_pipe.sv - scoreboard bench for alu_result_select_pipe

module tb_alu_result_select_pipe;

   localparam int WIDTH  = 24;
   localparam int NUM_IN = 8;
   localparam int SEL_W  = 3;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [NUM_IN*WIDTH-1:0] in_data = '0;
   logic [SEL_W-1:0]        sel = '0;
   logic                    in_valid = 1'b1;
   logic                    in_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_zero;
   logic                    out_illegal;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic                    err_sticky;
   logic                    err_clear = 1'b0;

   alu_result_select_pipe dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .sel         (sel),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_zero    (out_zero),
      .out_illegal (out_illegal),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .err_sticky  (err_sticky),
      .err_clear   (err_clear)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: legal codes are AND=0, OR=1, ADD=2, SLT=3, XOR=5.
   // Returns {illegal, zero, data}.
   function automatic logic [WIDTH+1:0] model(input logic [NUM_IN*WIDTH-1:0] d, input logic [SEL_W-1:0] s);
      int k;
      bit legal;
      logic [WIDTH-1:0] v;
      k = int'(s);
      legal = (k == 0) || (k == 1) || (k == 2) || (k == 3) || (k == 5);
      v = legal ? d[k*WIDTH +: WIDTH] : '0;
      return {!legal, (v == 0), v};
   endfunction

   function automatic logic [NUM_IN*WIDTH-1:0] rand_lanes();
      logic [NUM_IN*WIDTH-1:0] r;
      for (int i = 0; i < NUM_IN; i++)
         r[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      return r;
   endfunction

   // Scoreboard / monitor: sampled on the falling edge, where all inputs and
   // outputs already hold the values the next rising edge will see.
   logic [WIDTH+1:0] sb[$];
   bit               started = 0;
   bit               exp_sticky = 0;
   bit               hold = 0;
   logic [WIDTH+1:0] hold_val;

   always @(negedge clk) begin
      logic [WIDTH+1:0] e;
      if (reset) begin
         sb.delete();
         exp_sticky = 0;
         hold = 0;
         started = 1;
      end else if (started) begin
         check("err_sticky", 32'(err_sticky), 32'(exp_sticky));
         if (hold)
            check("hold_stable", {5'd0, out_valid, out_illegal, out_zero, out_data}, {5'd0, 1'b1, hold_val});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("beat_without_accept", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               check("out_beat", {6'd0, out_illegal, out_zero, out_data}, {6'd0, e});
            end
         end
         hold = out_valid && !out_ready;
         hold_val = {out_illegal, out_zero, out_data};
         if (in_valid && in_ready) begin
            e = model(in_data, sel);
            sb.push_back(e);
            if (e[WIDTH+1]) exp_sticky = 1;
            else if (err_clear) exp_sticky = 0;
         end else if (err_clear) begin
            exp_sticky = 0;
         end
      end
   end

   // Driver tasks: called and returning at posedge+1.
   task automatic wait_accept();
      bit got = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 0;
      err_clear = 0;
   endtask

   task automatic send(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] v, input bit clr);
      int k;
      k = int'(s);
      in_data = rand_lanes();
      in_data[k*WIDTH +: WIDTH] = v;
      sel = s;
      in_valid = 1;
      err_clear = clr;
      wait_accept();
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset held 2 cycles with in_valid asserted.
      step(2);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_err_sticky", 32'(err_sticky), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      reset = 0;
      in_valid = 0;
      step(1);

      // Streaming, one beat per cycle.
      out_ready = 1;
      send(3'd2, 24'h00ABCD, 0);
      check("stream0_data", 32'(out_data), 32'h00ABCD);
      check("stream0_zero", 32'(out_zero), 32'd0);
      send(3'd5, 24'hFFFFFF, 0);
      check("stream1_data", 32'(out_data), 32'hFFFFFF);
      check("stream1_valid", 32'(out_valid), 32'd1);

      // Illegal select.
      send(3'd4, 24'h123456, 0);
      check("illegal_data", 32'(out_data), 32'd0);
      check("illegal_zero", 32'(out_zero), 32'd1);
      check("illegal_flag", 32'(out_illegal), 32'd1);
      check("illegal_sticky", 32'(err_sticky), 32'd1);
      err_clear = 1;
      step(1);
      err_clear = 0;
      check("clear_sticky", 32'(err_sticky), 32'd0);
      step(2);

      // Backpressure: third beat must wait upstream.
      out_ready = 0;
      send(3'd0, 24'h000011, 0);
      send(3'd1, 24'h000022, 0);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      in_data = rand_lanes();
      in_data[3*WIDTH +: WIDTH] = 24'h000033;
      sel = 3'd3;
      in_valid = 1;
      step(3);
      check("bp_still_blocked", 32'(in_ready), 32'd0);
      check("bp_head_held", 32'(out_data), 32'h000011);
      out_ready = 1;
      wait_accept();
      step(4);

      // Illegal accept and clear in the same cycle: set wins.
      send(3'd6, 24'h0F0F0F, 1);
      check("simul_set_wins", 32'(err_sticky), 32'd1);
      err_clear = 1;
      step(1);
      err_clear = 0;

      // Reset with both registers full.
      out_ready = 0;
      send(3'd0, 24'hAAAAAA, 0);
      send(3'd2, 24'hBBBBBB, 0);
      check("full_in_ready", 32'(in_ready), 32'd0);
      reset = 1;
      step(1);
      reset = 0;
      check("rst_full_out_valid", 32'(out_valid), 32'd0);
      check("rst_full_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("rst_no_old_beat", 32'(out_valid), 32'd0);
      end

      // Randomized traffic with occasional mid-stream reset.
      for (int i = 0; i < 600; i++) begin
         in_data   = rand_lanes();
         sel       = SEL_W'($urandom_range(0, NUM_IN - 1));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         err_clear = ($urandom_range(0, 9) == 0);
         reset     = ($urandom_range(0, 99) == 0);
         step(1);
      end
      reset = 0;
      in_valid = 0;
      err_clear = 0;
      out_ready = 1;
      step(6);
      check("drain_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
